mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port (command/addr/data, plus response/tag return) between the instruction cache and the data cache.
- Replaces the fixed "dcache wins" mux in the core top. Arbitration is dcache-priority with a starvation guard for the icache.
- Keeps a tag-ownership table so each returning memory tag is steered to the cache that issued the load. The arbiter sits between both caches and the memory interface at the core top.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an icache request may be denied before it is forced to win.
- N_TAGS, 16: number of memory tag encodings (tag 0 = none); fixed by the 4-bit tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- icache2arb_command  in  2  BUS_NONE/BUS_LOAD from icache
- icache2arb_addr  in  XLEN  icache request address
- dcache2arb_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache
- dcache2arb_addr  in  XLEN  dcache request address
- dcache2arb_data  in  64  dcache store data
- mem2proc_response  in  4  memory accept tag for this cycle's command (0 = rejected)
- mem2proc_data  in  64  returning load data
- mem2proc_tag  in  4  tag of returning data (0 = none)
- proc2mem_command  out  2  granted command
- proc2mem_addr  out  XLEN  granted address
- proc2mem_data  out  64  dcache store data (driven for any grant; don't-care on loads)
- arb2icache_response  out  4  accept tag to icache (0 unless icache granted and accepted)
- arb2dcache_response  out  4  accept tag to dcache
- arb2icache_tag  out  4  return tag to icache (0 unless icache owns it)
- arb2dcache_tag  out  4  return tag to dcache
- arb2cache_data  out  64  mem2proc_data, broadcast to both caches
- grant_dcache  out  1  1 = dcache owns the port this cycle
- tag_error  out  1  sticky: a return arrived on an unallocated tag

Behaviour:
- Grant is combinational, evaluated every cycle:
  - If the dcache command is not BUS_NONE and starve_cnt < STARVE_LIMIT, the dcache wins.
  - Otherwise, if the icache command is not BUS_NONE, the icache wins.
  - Otherwise the dcache wins (idle; drives BUS_NONE).
- The memory port outputs mirror the winner's command and address. The loser sees response 0 and must hold and retry; the same response=0 semantics apply as for a memory rejection.
- starve_cnt (registered, width clog2(STARVE_LIMIT)+1):
  - Increments when icache_cmd != NONE and the dcache wins.
  - Clears when the icache is granted or icache_cmd == NONE.
  - Saturates at STARVE_LIMIT. At the limit the icache wins the next cycle even if the dcache is requesting.
- Response routing (combinational): mem2proc_response goes only to the granted cache's *_response port; the other port gets 0.
- Owner table, registered per tag 1..15 (valid bit + owner bit):
  - Allocates on an accepted BUS_LOAD (response != 0) with owner = the granted cache.
  - Accepted BUS_STORE does not allocate; stores produce no data return.
- Return routing:
  - When mem2proc_tag != 0 and the entry is valid, drive the tag only on the owner's *_tag port, then clear valid at the clock edge.
  - If the entry is invalid, drive both *_tag ports to 0 and set tag_error, which stays set until reset.
- Same-cycle return and allocate on the same tag: the return is routed using the old owner. The entry then ends valid with the new owner (allocate wins the write).
- Allocating a tag whose entry is still valid overwrites it and sets tag_error (a memory protocol violation).
- Reset values: table all invalid, starve_cnt = 0, tag_error = 0. All combinational outputs default to 0/BUS_NONE when both commands are NONE.
- Reset mid-transaction: outstanding entries are dropped. Later returns on those tags set tag_error only if they arrive after reset deasserts; the bench gates this.
- Widths: tags are 4 bits; tag 0 is never allocated or routed.

Decomposition:
- Shared package holds: BUS_NONE/BUS_LOAD/BUS_STORE enum, the MEM_TAG typedef (4 bits), the REQ_ICACHE/REQ_DCACHE owner encoding, and STARVE_LIMIT default.
- One sub-module, mem_tag_table: owner table with allocate/lookup-and-free ports and error flag. The arbitration logic stays in the top.

Test Plan:
- Dcache LOAD and icache LOAD at the same time, memory response=3 -> proc2mem_command=LOAD with the dcache address; arb2dcache_response=3, arb2icache_response=0. Later mem2proc_tag=3 -> arb2dcache_tag=3, arb2icache_tag=0.
- Dcache requests continuously and icache holds a LOAD, STARVE_LIMIT=4 -> dcache granted cycles 0-3, icache granted cycle 4, starve_cnt back to 0 in cycle 5.
- Icache LOAD accepted tag 5, dcache STORE accepted tag 6, mem2proc_tag=5 -> arb2icache_tag=5. Later mem2proc_tag=6 (never allocated, since stores do not allocate) -> both tag ports 0, tag_error=1 and stays 1.
- Tag 7 owned by icache returns in the same cycle the dcache LOAD is accepted with tag 7 -> arb2icache_tag=7 this cycle. Next return on tag 7 goes to the dcache.
- Memory rejects (response=0) the granted icache LOAD -> arb2icache_response=0, no table entry. Retry next cycle with response=2 -> allocated and later routed to the icache.
- Reset asserted with tags 1 and 2 outstanding -> table cleared, starve_cnt=0, tag_error=0, all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus encodings, tag type and owner encoding for the memory arbiter
package mem_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int N_TAGS = 16;
    localparam int DEFAULT_STARVE_LIMIT = 4;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;
    typedef logic [3:0] MEM_TAG;
    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } req_owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the shared memory port
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    bus_command_t           icache2arb_command;
    logic [XLEN-1:0]        icache2arb_addr;
    bus_command_t           dcache2arb_command;
    logic [XLEN-1:0]        dcache2arb_addr;
    logic [63:0]            dcache2arb_data;
    MEM_TAG                 mem2proc_response;
    logic [63:0]            mem2proc_data;
    MEM_TAG                 mem2proc_tag;
    bus_command_t           proc2mem_command;
    logic [XLEN-1:0]        proc2mem_addr;
    logic [63:0]            proc2mem_data;
    MEM_TAG                 arb2icache_response;
    MEM_TAG                 arb2dcache_response;
    MEM_TAG                 arb2icache_tag;
    MEM_TAG                 arb2dcache_tag;
    logic [63:0]            arb2cache_data;
    logic                   grant_dcache;
    logic                   tag_error;
    modport slave (
        input  icache2arb_command, icache2arb_addr, dcache2arb_command, dcache2arb_addr,
               dcache2arb_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data, arb2icache_response,
               arb2dcache_response, arb2icache_tag, arb2dcache_tag, arb2cache_data,
               grant_dcache, tag_error
    );
    modport master (
        output icache2arb_command, icache2arb_addr, dcache2arb_command, dcache2arb_addr,
               dcache2arb_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, arb2icache_response,
               arb2dcache_response, arb2icache_tag, arb2dcache_tag, arb2cache_data,
               grant_dcache, tag_error
    );
endinterface

// File: rtl/mem_tag_table.sv
// mem_tag_table: per-tag owner table; allocates on accepted loads, frees on returns, flags protocol errors
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       alloc_en,
    input  MEM_TAG     alloc_tag,
    input  req_owner_t alloc_owner,
    input  MEM_TAG     ret_tag,
    output logic       ret_valid,
    output req_owner_t ret_owner,
    output logic       tag_error
);
    logic [N_TAGS-1:0] valid;
    logic [N_TAGS-1:0] owner;
    always_comb begin
        ret_valid = (ret_tag != '0) && valid[ret_tag];
        ret_owner = req_owner_t'(owner[ret_tag]);
    end
    // the allocate write comes last so it wins over a same-cycle free of the same tag
    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= '0;
            owner     <= '0;
            tag_error <= 1'b0;
        end else begin
            if (ret_tag != '0) valid[ret_tag] <= 1'b0;
            if (alloc_en) begin
                valid[alloc_tag] <= 1'b1;
                owner[alloc_tag] <= alloc_owner;
            end
            if ((ret_tag != '0 && !ret_valid) || (alloc_en && valid[alloc_tag] && alloc_tag != ret_tag))
                tag_error <= 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: dcache-priority arbiter for the shared memory port with an icache starvation guard
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt;
    logic          ireq, dreq, grant_i, grant_d;
    logic          ret_valid;
    req_owner_t    ret_owner;
    always_comb begin
        ireq    = bus.icache2arb_command != BUS_NONE;
        dreq    = bus.dcache2arb_command != BUS_NONE;
        grant_i = ireq && (!dreq || starve_cnt >= LIMIT);
        grant_d = !grant_i;
        bus.grant_dcache        = grant_d;
        bus.proc2mem_command    = grant_i ? bus.icache2arb_command : bus.dcache2arb_command;
        bus.proc2mem_addr       = grant_i ? bus.icache2arb_addr : (dreq ? bus.dcache2arb_addr : '0);
        bus.proc2mem_data       = (ireq || dreq) ? bus.dcache2arb_data : '0;
        bus.arb2icache_response = grant_i ? bus.mem2proc_response : '0;
        bus.arb2dcache_response = (grant_d && dreq) ? bus.mem2proc_response : '0;
        bus.arb2icache_tag      = (ret_valid && ret_owner == REQ_ICACHE) ? bus.mem2proc_tag : '0;
        bus.arb2dcache_tag      = (ret_valid && ret_owner == REQ_DCACHE) ? bus.mem2proc_tag : '0;
        bus.arb2cache_data      = bus.mem2proc_data;
    end
    always_ff @(posedge clock) begin
        if (reset || !ireq || grant_i) starve_cnt <= '0;
        else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
    mem_tag_table u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (bus.proc2mem_command == BUS_LOAD && bus.mem2proc_response != '0),
        .alloc_tag   (bus.mem2proc_response),
        .alloc_owner (grant_d ? REQ_DCACHE : REQ_ICACHE),
        .ret_tag     (bus.mem2proc_tag),
        .ret_valid   (ret_valid),
        .ret_owner   (ret_owner),
        .tag_error   (bus.tag_error)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected return routing is queued at accept time and checked on return
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
    typedef struct {
        logic [3:0] tag;
        logic [3:0] itag;
        logic [3:0] dtag;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    exp_t e;
    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_LIMIT(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.icache2arb_command = BUS_NONE;
        bus.icache2arb_addr    = '0;
        bus.dcache2arb_command = BUS_NONE;
        bus.dcache2arb_addr    = '0;
        bus.dcache2arb_data    = '0;
        bus.mem2proc_response  = '0;
        bus.mem2proc_data      = '0;
        bus.mem2proc_tag       = '0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (bus.proc2mem_command !== BUS_NONE) begin n_bad++; $display("FAIL reset_cmd: got %0h want 0", bus.proc2mem_command); end
        n_cmp++; if (bus.proc2mem_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", bus.proc2mem_addr); end
        n_cmp++; if (bus.proc2mem_data !== '0) begin n_bad++; $display("FAIL reset_data: got %0h want 0", bus.proc2mem_data); end
        n_cmp++; if ({bus.arb2icache_response, bus.arb2dcache_response} !== 8'h00) begin n_bad++; $display("FAIL reset_resp: got %0h/%0h want 0/0", bus.arb2icache_response, bus.arb2dcache_response); end
        n_cmp++; if ({bus.arb2icache_tag, bus.arb2dcache_tag} !== 8'h00) begin n_bad++; $display("FAIL reset_tags: got %0h/%0h want 0/0", bus.arb2icache_tag, bus.arb2dcache_tag); end
        n_cmp++; if (bus.tag_error !== 1'b0) begin n_bad++; $display("FAIL reset_tag_error: got %0b want 0", bus.tag_error); end
        n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
    endtask

    task automatic test_priority();
        step();
        bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = 32'h100;
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = 32'h200;
        bus.mem2proc_response  = 4'd3;
        #1;
        n_cmp++; if (bus.proc2mem_command !== BUS_LOAD) begin n_bad++; $display("FAIL prio_cmd: got %0h want 1", bus.proc2mem_command); end
        n_cmp++; if (bus.proc2mem_addr !== 32'h100) begin n_bad++; $display("FAIL prio_addr: got %0h want 100", bus.proc2mem_addr); end
        n_cmp++; if (bus.arb2dcache_response !== 4'd3) begin n_bad++; $display("FAIL prio_dresp: got %0d want 3", bus.arb2dcache_response); end
        n_cmp++; if (bus.arb2icache_response !== 4'd0) begin n_bad++; $display("FAIL prio_iresp: got %0d want 0", bus.arb2icache_response); end
        n_cmp++; if (bus.grant_dcache !== 1'b1) begin n_bad++; $display("FAIL prio_grant: got %0b want 1", bus.grant_dcache); end
        exp_q.push_back('{tag: 4'd3, itag: 4'd0, dtag: 4'd3});
        step();
        idle();
        step();
        e = exp_q.pop_front();
        bus.mem2proc_tag = e.tag; bus.mem2proc_data = 64'h1234_5678_9abc_def0;
        #1;
        n_cmp++; if (bus.arb2dcache_tag !== e.dtag) begin n_bad++; $display("FAIL prio_ret_dtag: got %0d want %0d", bus.arb2dcache_tag, e.dtag); end
        n_cmp++; if (bus.arb2icache_tag !== e.itag) begin n_bad++; $display("FAIL prio_ret_itag: got %0d want %0d", bus.arb2icache_tag, e.itag); end
        n_cmp++; if (bus.arb2cache_data !== 64'h1234_5678_9abc_def0) begin n_bad++; $display("FAIL prio_ret_data: got %0h want 123456789abcdef0", bus.arb2cache_data); end
        step();
        idle();
    endtask

    task automatic test_starvation();
        step();
        bus.dcache2arb_command = BUS_STORE; bus.dcache2arb_addr = 32'h400;
        bus.icache2arb_command = BUS_LOAD;  bus.icache2arb_addr = 32'h500;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if (bus.grant_dcache !== (c != 4)) begin n_bad++; $display("FAIL starve_grant_c%0d: got %0b want %0b", c, bus.grant_dcache, c != 4); end
            n_cmp++; if (int'(dut.starve_cnt) !== (c <= 4 ? c : 0)) begin n_bad++; $display("FAIL starve_cnt_c%0d: got %0d want %0d", c, dut.starve_cnt, c <= 4 ? c : 0); end
            if (c == 4) begin
                n_cmp++; if (bus.proc2mem_addr !== 32'h500) begin n_bad++; $display("FAIL starve_addr: got %0h want 500", bus.proc2mem_addr); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_reject_retry();
        step();
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = 32'h80; bus.mem2proc_response = 4'd0;
        #1;
        n_cmp++; if (bus.proc2mem_command !== BUS_LOAD) begin n_bad++; $display("FAIL rej_cmd: got %0h want 1", bus.proc2mem_command); end
        n_cmp++; if (bus.arb2icache_response !== 4'd0) begin n_bad++; $display("FAIL rej_iresp: got %0d want 0", bus.arb2icache_response); end
        step();
        bus.mem2proc_response = 4'd2;
        #1;
        n_cmp++; if (bus.arb2icache_response !== 4'd2) begin n_bad++; $display("FAIL retry_iresp: got %0d want 2", bus.arb2icache_response); end
        exp_q.push_back('{tag: 4'd2, itag: 4'd2, dtag: 4'd0});
        step();
        idle();
        step();
        e = exp_q.pop_front();
        bus.mem2proc_tag = e.tag;
        #1;
        n_cmp++; if (bus.arb2icache_tag !== e.itag) begin n_bad++; $display("FAIL retry_ret_itag: got %0d want %0d", bus.arb2icache_tag, e.itag); end
        n_cmp++; if (bus.arb2dcache_tag !== e.dtag) begin n_bad++; $display("FAIL retry_ret_dtag: got %0d want %0d", bus.arb2dcache_tag, e.dtag); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.tag_error !== 1'b0) begin n_bad++; $display("FAIL retry_tag_error: got %0b want 0", bus.tag_error); end
    endtask

    task automatic test_same_cycle();
        step();
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = 32'h700; bus.mem2proc_response = 4'd7;
        #1;
        n_cmp++; if (bus.arb2icache_response !== 4'd7) begin n_bad++; $display("FAIL same_iresp: got %0d want 7", bus.arb2icache_response); end
        exp_q.push_back('{tag: 4'd7, itag: 4'd7, dtag: 4'd0});
        step();
        idle();
        step();
        bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = 32'h300; bus.mem2proc_response = 4'd7;
        e = exp_q.pop_front();
        bus.mem2proc_tag = e.tag;
        #1;
        n_cmp++; if (bus.arb2icache_tag !== e.itag) begin n_bad++; $display("FAIL same_ret_itag: got %0d want %0d", bus.arb2icache_tag, e.itag); end
        n_cmp++; if (bus.arb2dcache_tag !== e.dtag) begin n_bad++; $display("FAIL same_ret_dtag: got %0d want %0d", bus.arb2dcache_tag, e.dtag); end
        n_cmp++; if (bus.arb2dcache_response !== 4'd7) begin n_bad++; $display("FAIL same_dresp: got %0d want 7", bus.arb2dcache_response); end
        exp_q.push_back('{tag: 4'd7, itag: 4'd0, dtag: 4'd7});
        step();
        idle();
        step();
        e = exp_q.pop_front();
        bus.mem2proc_tag = e.tag;
        #1;
        n_cmp++; if (bus.arb2dcache_tag !== e.dtag) begin n_bad++; $display("FAIL same_next_dtag: got %0d want %0d", bus.arb2dcache_tag, e.dtag); end
        n_cmp++; if (bus.arb2icache_tag !== e.itag) begin n_bad++; $display("FAIL same_next_itag: got %0d want %0d", bus.arb2icache_tag, e.itag); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.tag_error !== 1'b0) begin n_bad++; $display("FAIL same_tag_error: got %0b want 0", bus.tag_error); end
    endtask

    task automatic test_store_no_alloc();
        step();
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = 32'h50; bus.mem2proc_response = 4'd5;
        #1;
        n_cmp++; if (bus.arb2icache_response !== 4'd5) begin n_bad++; $display("FAIL st_iresp: got %0d want 5", bus.arb2icache_response); end
        n_cmp++; if (bus.proc2mem_addr !== 32'h50) begin n_bad++; $display("FAIL st_iaddr: got %0h want 50", bus.proc2mem_addr); end
        exp_q.push_back('{tag: 4'd5, itag: 4'd5, dtag: 4'd0});
        step();
        idle();
        bus.dcache2arb_command = BUS_STORE; bus.dcache2arb_addr = 32'h60; bus.dcache2arb_data = 64'hdead_beef;
        bus.mem2proc_response = 4'd6;
        #1;
        n_cmp++; if (bus.proc2mem_command !== BUS_STORE) begin n_bad++; $display("FAIL st_cmd: got %0h want 2", bus.proc2mem_command); end
        n_cmp++; if (bus.proc2mem_data !== 64'hdead_beef) begin n_bad++; $display("FAIL st_data: got %0h want deadbeef", bus.proc2mem_data); end
        n_cmp++; if (bus.arb2dcache_response !== 4'd6) begin n_bad++; $display("FAIL st_dresp: got %0d want 6", bus.arb2dcache_response); end
        step();
        idle();
        e = exp_q.pop_front();
        bus.mem2proc_tag = e.tag;
        #1;
        n_cmp++; if (bus.arb2icache_tag !== e.itag) begin n_bad++; $display("FAIL st_ret_itag: got %0d want %0d", bus.arb2icache_tag, e.itag); end
        n_cmp++; if (bus.arb2dcache_tag !== e.dtag) begin n_bad++; $display("FAIL st_ret_dtag: got %0d want %0d", bus.arb2dcache_tag, e.dtag); end
        step();
        bus.mem2proc_tag = 4'd6;
        #1;
        n_cmp++; if ({bus.arb2icache_tag, bus.arb2dcache_tag} !== 8'h00) begin n_bad++; $display("FAIL st_bad_tags: got %0h/%0h want 0/0", bus.arb2icache_tag, bus.arb2dcache_tag); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.tag_error !== 1'b1) begin n_bad++; $display("FAIL st_tag_error: got %0b want 1", bus.tag_error); end
        step();
        step();
        n_cmp++; if (bus.tag_error !== 1'b1) begin n_bad++; $display("FAIL st_tag_error_sticky: got %0b want 1", bus.tag_error); end
    endtask

    task automatic test_reset_mid();
        step();
        bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = 32'h10; bus.mem2proc_response = 4'd1;
        step();
        idle();
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = 32'h20; bus.mem2proc_response = 4'd2;
        step();
        apply_reset();
        #1;
        n_cmp++; if (bus.tag_error !== 1'b0) begin n_bad++; $display("FAIL rmid_tag_error: got %0b want 0", bus.tag_error); end
        n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL rmid_starve: got %0d want 0", dut.starve_cnt); end
        n_cmp++; if (bus.proc2mem_command !== BUS_NONE || bus.proc2mem_addr !== '0) begin n_bad++; $display("FAIL rmid_port: got %0h/%0h want 0/0", bus.proc2mem_command, bus.proc2mem_addr); end
        step();
        bus.mem2proc_tag = 4'd1;
        #1;
        n_cmp++; if ({bus.arb2icache_tag, bus.arb2dcache_tag} !== 8'h00) begin n_bad++; $display("FAIL rmid_dropped_tags: got %0h/%0h want 0/0", bus.arb2icache_tag, bus.arb2dcache_tag); end
        step();
        idle();
        #1;
        n_cmp++; if (bus.tag_error !== 1'b1) begin n_bad++; $display("FAIL rmid_late_error: got %0b want 1", bus.tag_error); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_starvation();
        test_reject_retry();
        test_same_cycle();
        test_store_no_alloc();
        apply_reset();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
